// File: rtl/imm_issue_ctrl.sv
// imm_issue_ctrl: decode-to-execute immediate stage with a one-entry valid/ready slot.
// An UPPER constant followed by a LOWER constant to the same rd is fused into one immediate.
`default_nettype none

module imm_issue_ctrl #(
   parameter logic [5:0]  UPPER_OP  = 6'b111000,
   parameter logic [5:0]  LOWER_OP  = 6'b110001,
   parameter int unsigned FUSE_WAIT = 2,
   parameter bit          FUSE_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        id_valid,
   input  logic [31:0] id_instr,
   output logic        id_ready,
   output logic [25:0] imm_in,
   output logic [3:0]  imm_src,
   input  logic [31:0] imm_ext,
   output logic        ex_valid,
   input  logic        ex_ready,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rd,
   output logic        ex_fused
);

   typedef enum logic [1:0] {
      EMPTY      = 2'd0,
      FULL       = 2'd1,
      UPPER_WAIT = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(FUSE_WAIT - 1);

   state_t      state, state_nxt;
   logic [31:0] upper_imm, upper_imm_nxt;
   logic [4:0]  upper_rd, upper_rd_nxt;
   logic [3:0]  wait_cnt, wait_cnt_nxt;
   logic        ex_valid_nxt, ex_fused_nxt;
   logic [31:0] ex_imm_nxt;
   logic [4:0]  ex_rd_nxt;

   logic [5:0] opcode;
   logic [4:0] rd;
   logic       is_upper, lower_match, accept;

   assign opcode      = id_instr[31:26];
   assign rd          = id_instr[4:0];
   assign imm_in      = id_instr[25:0];
   assign is_upper    = (opcode == UPPER_OP);
   assign lower_match = id_valid && (opcode == LOWER_OP) && (rd == upper_rd);
   assign imm_src     = is_upper ? 4'b0010 : {opcode[5:4], 1'b0, opcode[0]};
   assign accept      = id_valid && id_ready;

   always_comb begin
      id_ready = 1'b0;
      case (state)
         EMPTY:      id_ready = 1'b1;
         FULL:       id_ready = ex_ready;
         UPPER_WAIT: id_ready = lower_match;
         default:    id_ready = 1'b0;
      endcase
      // Flush wins over any handshake in the same cycle.
      if (flush) id_ready = 1'b0;
   end

   always_comb begin
      state_nxt     = state;
      upper_imm_nxt = upper_imm;
      upper_rd_nxt  = upper_rd;
      wait_cnt_nxt  = wait_cnt;
      ex_valid_nxt  = ex_valid;
      ex_imm_nxt    = ex_imm;
      ex_rd_nxt     = ex_rd;
      ex_fused_nxt  = ex_fused;
      if (flush) begin
         state_nxt    = EMPTY;
         ex_valid_nxt = 1'b0;
         wait_cnt_nxt = 4'd0;
      end else begin
         case (state)
            EMPTY, FULL: begin
               if (state == EMPTY || ex_ready) begin
                  state_nxt    = EMPTY;
                  ex_valid_nxt = 1'b0;
                  if (accept) begin
                     if (is_upper && FUSE_EN) begin
                        upper_imm_nxt = imm_ext;
                        upper_rd_nxt  = rd;
                        wait_cnt_nxt  = 4'd0;
                        state_nxt     = UPPER_WAIT;
                     end else begin
                        state_nxt    = FULL;
                        ex_valid_nxt = 1'b1;
                        ex_imm_nxt   = imm_ext;
                        ex_rd_nxt    = rd;
                        ex_fused_nxt = 1'b0;
                     end
                  end
               end
            end
            UPPER_WAIT: begin
               if (accept) begin
                  state_nxt    = FULL;
                  ex_valid_nxt = 1'b1;
                  ex_imm_nxt   = upper_imm | imm_ext;
                  ex_rd_nxt    = upper_rd;
                  ex_fused_nxt = 1'b1;
               end else if (id_valid || wait_cnt == WAIT_LAST) begin
                  // Give up on fusion: issue the held UPPER by itself.
                  state_nxt    = FULL;
                  ex_valid_nxt = 1'b1;
                  ex_imm_nxt   = upper_imm;
                  ex_rd_nxt    = upper_rd;
                  ex_fused_nxt = 1'b0;
               end else begin
                  wait_cnt_nxt = wait_cnt + 4'd1;
               end
            end
            default: begin
               state_nxt    = EMPTY;
               ex_valid_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         upper_imm <= 32'd0;
         upper_rd  <= 5'd0;
         wait_cnt  <= 4'd0;
         ex_valid  <= 1'b0;
         ex_imm    <= 32'd0;
         ex_rd     <= 5'd0;
         ex_fused  <= 1'b0;
      end else begin
         state     <= state_nxt;
         upper_imm <= upper_imm_nxt;
         upper_rd  <= upper_rd_nxt;
         wait_cnt  <= wait_cnt_nxt;
         ex_valid  <= ex_valid_nxt;
         ex_imm    <= ex_imm_nxt;
         ex_rd     <= ex_rd_nxt;
         ex_fused  <= ex_fused_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imm_issue_ctrl.sv
// tb_imm_issue_ctrl: directed and random stimulus against a transaction-level model of the issue stage.
`default_nettype none

module tb_imm_issue_ctrl;

   localparam logic [5:0] UPPER_OP  = 6'b111000;
   localparam logic [5:0] LOWER_OP  = 6'b110001;
   localparam int         FUSE_WAIT = 2;
   localparam bit         FUSE_EN   = 1'b1;

   logic        clk = 1'b0;
   logic        rst, flush, id_valid, ex_ready;
   logic [31:0] id_instr, imm_ext;
   logic        id_ready, ex_valid, ex_fused;
   logic [25:0] imm_in;
   logic [3:0]  imm_src;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;

   int checks = 0;
   int errors = 0;

   // Reference model state: slot contents and an optional held UPPER.
   bit          m_sv, m_fu, m_pend;
   logic [31:0] m_imm, m_pimm;
   logic [4:0]  m_rd, m_prd;
   int          m_idle;

   imm_issue_ctrl #(
      .UPPER_OP(UPPER_OP), .LOWER_OP(LOWER_OP), .FUSE_WAIT(FUSE_WAIT), .FUSE_EN(FUSE_EN)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_instr(id_instr),
      .id_ready(id_ready), .imm_in(imm_in), .imm_src(imm_src), .imm_ext(imm_ext),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_fused(ex_fused)
   );

   always #5 clk = ~clk;

   // Extender stand-in: upper form puts imm[25:5] at the top; others extend imm[25:10].
   function automatic logic [31:0] ext_fn(input logic [3:0] src, input logic [25:0] imm);
      if (src == 4'b0010) return {imm[25:5], 11'd0};
      else if (src[0])    return {16'd0, imm[25:10]};
      else                return {{16{imm[25]}}, imm[25:10]};
   endfunction

   assign imm_ext = ext_fn(imm_src, imm_in);

   function automatic logic [3:0] model_src(input logic [5:0] op);
      if (op == UPPER_OP) return 4'b0010;
      return {op[5:4], 1'b0, op[0]};
   endfunction

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] f, input logic [4:0] r);
      return {op, f, 5'd0, r};
   endfunction

   function automatic logic [31:0] mk_upper(input logic [4:0] r);
      return {UPPER_OP, 21'h2468B, r};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sv = 0; m_fu = 0; m_pend = 0; m_imm = 0; m_pimm = 0; m_rd = 0; m_prd = 0; m_idle = 0;
   endtask

   task automatic model_load(input logic [31:0] v, input logic [4:0] r, input bit f);
      m_sv = 1; m_imm = v; m_rd = r; m_fu = f;
   endtask

   task automatic check_ex();
      check("ex_valid", 32'(ex_valid), 32'(m_sv));
      check("ex_imm", ex_imm, m_imm);
      check("ex_rd", 32'(ex_rd), 32'(m_rd));
      check("ex_fused", 32'(ex_fused), 32'(m_fu));
   endtask

   task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
      bit          mrdy, acc;
      logic [31:0] mext;
      @(negedge clk);
      id_valid = v; id_instr = ins; ex_ready = rdy; flush = fl;
      #1;
      if (fl)          mrdy = 0;
      else if (m_pend) mrdy = v && ins[31:26] == LOWER_OP && ins[4:0] == m_prd;
      else if (m_sv)   mrdy = rdy;
      else             mrdy = 1;
      acc  = v && mrdy;
      mext = ext_fn(model_src(ins[31:26]), ins[25:0]);
      check("id_ready", 32'(id_ready), 32'(mrdy));
      check("imm_in", 32'(imm_in), 32'(ins[25:0]));
      check("imm_src", 32'(imm_src), 32'(model_src(ins[31:26])));
      @(posedge clk);
      if (fl) begin
         m_sv = 0; m_pend = 0; m_idle = 0;
      end else if (m_pend) begin
         if (acc) begin
            model_load(m_pimm | mext, m_prd, 1); m_pend = 0;
         end else if (v) begin
            model_load(m_pimm, m_prd, 0); m_pend = 0;
         end else begin
            m_idle++;
            if (m_idle == FUSE_WAIT) begin
               model_load(m_pimm, m_prd, 0); m_pend = 0;
            end
         end
      end else if (!(m_sv && !rdy)) begin
         m_sv = 0;
         if (acc) begin
            if (ins[31:26] == UPPER_OP && FUSE_EN) begin
               m_pend = 1; m_pimm = mext; m_prd = ins[4:0]; m_idle = 0;
            end else begin
               model_load(mext, ins[4:0], 0);
            end
         end
      end
      #1;
      check_ex();
   endtask

   initial begin
      logic [5:0] op;
      rst = 1; flush = 0; id_valid = 0; id_instr = 32'd0; ex_ready = 1;
      model_reset();
      #1;
      check_ex();
      @(negedge clk); rst = 0;

      // Type b signed immediate
      step(1, mk(6'b000000, 16'h8001, 5'd3), 1, 0);
      check("typeb_imm", ex_imm, 32'hFFFF8001);
      check("typeb_rd", 32'(ex_rd), 32'd3);
      step(0, 32'd0, 1, 0);

      // Fusion of UPPER and LOWER to rd 7
      step(1, mk_upper(5'd7), 1, 0);
      check("fuse_hold", 32'(ex_valid), 32'd0);
      step(1, mk(LOWER_OP, 16'h0567, 5'd7), 1, 0);
      check("fuse_imm", ex_imm, 32'h12345D67);
      check("fuse_flag", 32'(ex_fused), 32'd1);
      step(0, 32'd0, 1, 0);

      // rd mismatch: UPPER issues alone, then the stalled LOWER
      step(1, mk_upper(5'd7), 1, 0);
      step(1, mk(LOWER_OP, 16'h0567, 5'd8), 1, 0);
      check("mm_beat1", ex_imm, 32'h12345800);
      step(1, mk(LOWER_OP, 16'h0567, 5'd8), 1, 0);
      check("mm_beat2_rd", 32'(ex_rd), 32'd8);
      step(0, 32'd0, 1, 0);

      // Timeout after FUSE_WAIT idle cycles
      step(1, mk_upper(5'd7), 1, 0);
      step(0, 32'd0, 1, 0);
      step(0, 32'd0, 1, 0);
      check("timeout_valid", 32'(ex_valid), 32'd1);
      step(0, 32'd0, 1, 0);

      // Backpressure
      step(1, mk(6'b010011, 16'h00AA, 5'd4), 1, 0);
      for (int i = 0; i < 3; i++) step(1, mk(6'b000001, 16'h0055, 5'd5), 0, 0);
      check("bp_hold_rd", 32'(ex_rd), 32'd4);
      step(1, mk(6'b000001, 16'h0055, 5'd5), 1, 0);
      check("bp_next_rd", 32'(ex_rd), 32'd5);
      step(0, 32'd0, 1, 0);

      // Flush while holding an UPPER
      step(1, mk_upper(5'd7), 1, 0);
      step(1, mk(LOWER_OP, 16'h0567, 5'd7), 1, 1);
      check("flush_valid", 32'(ex_valid), 32'd0);
      step(1, mk(LOWER_OP, 16'h0567, 5'd7), 1, 0);
      check("flush_unfused", 32'(ex_fused), 32'd0);

      // Asynchronous reset while FULL
      step(1, mk(6'b000000, 16'h1234, 5'd9), 0, 0);
      @(negedge clk);
      #2 rst = 1;
      #1;
      model_reset();
      check("rst_async_valid", 32'(ex_valid), 32'd0);
      check_ex();
      @(negedge clk); rst = 0;
      step(1, mk(LOWER_OP, 16'h0567, 5'd7), 1, 0);
      check("rst_unfused", 32'(ex_fused), 32'd0);
      check("rst_lower_imm", ex_imm, 32'h00000567);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       op = UPPER_OP;
            1:       op = LOWER_OP;
            default: op = 6'($urandom);
         endcase
         step(($urandom_range(0, 3) != 0),
              {op, 21'($urandom), 5'($urandom_range(7, 8))},
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 19) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
